// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Purpose : Load-type encodings, load FSM states and misalignment helper.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam logic [2:0] c_LB  = 3'b000;
  localparam logic [2:0] c_LH  = 3'b001;
  localparam logic [2:0] c_LW  = 3'b010;
  localparam logic [2:0] c_LBU = 3'b100;
  localparam logic [2:0] c_LHU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic is_misaligned(input logic [2:0] i_type,
                                         input logic [1:0] i_addr);
    case (i_type)
      c_LH, c_LHU: is_misaligned = i_addr[0];
      c_LW:        is_misaligned = (i_addr != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// ============================================================================
// Module  : load_extend
// Purpose : Little-endian byte/halfword lane select with sign/zero extension.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_type,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
  end

  // Unknown type codes fall through to a full-word load.
  always_comb begin
    o_data = i_word;
    case (i_type)
      c_LB:    o_data = {{24{w_byte[7]}}, w_byte};
      c_LBU:   o_data = {24'h0, w_byte};
      c_LH:    o_data = {{16{w_half[15]}}, w_half};
      c_LHU:   o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_load_unit.sv
// ============================================================================
// Module  : mem_load_unit
// Purpose : MEM-stage load sequencer: request, response wait, flush drain,
//           timeout bus error. Define LOAD_MISALIGN_TRAP_EN to trap misaligned
//           LH/LHU/LW with MEM_AddrErr instead of issuing them.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_load_unit
  import mem_pkg::*;
#(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_LoadReq,
  input  logic [2:0]  MEM_LoadType,
  input  logic [31:0] MEM_Addr,
  input  logic        MEM_Flush,
  output logic        DMem_ReqValid,
  output logic [31:0] DMem_ReqAddr,
  input  logic        DMem_ReqReady,
  input  logic        DMem_RespValid,
  input  logic [31:0] DMem_RespData,
  output logic [31:0] MEM_ReadData,
  output logic        MEM_ReadValid,
  output logic        MEM_Stall,
  output logic        MEM_BusErr,
  output logic        MEM_AddrErr
);

  localparam int c_CNT_W = ($clog2(RESP_TIMEOUT + 1) > 8) ? $clog2(RESP_TIMEOUT + 1) : 8;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(RESP_TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_addr;
  logic [2:0]         r_type;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_rdata;
  logic               r_buserr;
  logic [31:0]        w_ext;
  logic               w_start;
  logic               w_timeout;
  logic               w_misalign;
  logic               w_addrerr;

  assign w_start   = MEM_LoadReq && !MEM_Flush;
  assign w_timeout = (r_cnt == c_CNT_LAST);

`ifdef LOAD_MISALIGN_TRAP_EN
  logic r_addrerr;

  assign w_misalign = is_misaligned(MEM_LoadType, MEM_Addr[1:0]);
  assign w_addrerr  = r_addrerr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_addrerr <= 1'b0;
    else     r_addrerr <= (r_state == S_IDLE) && w_start && w_misalign;
  end
`else
  assign w_misalign = 1'b0;
  assign w_addrerr  = 1'b0;
`endif

  load_extend u_extend (
    .i_word (DMem_RespData),
    .i_addr (r_addr[1:0]),
    .i_type (r_type),
    .o_data (w_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // A flush that coincides with a response has already consumed it, so
  // there is nothing left to drain.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = w_misalign ? S_DONE : S_REQ;
      S_REQ: begin
        if (MEM_Flush)
          w_next = (DMem_ReqReady && !DMem_RespValid) ? S_DRAIN : S_IDLE;
        else if (DMem_ReqReady)
          w_next = DMem_RespValid ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (DMem_RespValid)  w_next = MEM_Flush ? S_IDLE : S_DONE;
        else if (MEM_Flush)  w_next = S_DRAIN;
        else if (w_timeout)  w_next = S_DONE;
      end
      S_DRAIN: if (DMem_RespValid || w_timeout) w_next = S_IDLE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_type   <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_buserr <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_start) begin
        r_addr <= MEM_Addr;
        r_type <= MEM_LoadType;
      end
      if (r_state == S_WAIT || r_state == S_DRAIN) begin
        if (!w_timeout) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      r_buserr <= 1'b0;
      if (w_next == S_DONE) begin
        case (r_state)
          S_IDLE: r_rdata <= '0;
          S_WAIT: begin
            if (DMem_RespValid) begin
              r_rdata <= w_ext;
            end else begin
              r_rdata  <= '0;
              r_buserr <= 1'b1;
            end
          end
          default: r_rdata <= w_ext;
        endcase
      end
    end
  end

  // Outputs are gated by rst so they read zero while reset is held.
  always_comb begin
    DMem_ReqValid = 1'b0;
    MEM_Stall     = 1'b0;
    MEM_ReadValid = 1'b0;
    MEM_BusErr    = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE:          MEM_Stall = w_start;
        S_REQ: begin
          DMem_ReqValid = 1'b1;
          MEM_Stall     = 1'b1;
        end
        S_WAIT, S_DRAIN: MEM_Stall = 1'b1;
        S_DONE: begin
          MEM_ReadValid = !r_buserr && !w_addrerr && !MEM_Flush;
          MEM_BusErr    = r_buserr;
        end
        default: MEM_Stall = 1'b0;
      endcase
    end
  end

  assign DMem_ReqAddr = {r_addr[31:2], 2'b00};
  assign MEM_ReadData = r_rdata;
  assign MEM_AddrErr  = w_addrerr;

endmodule

`default_nettype wire

// File: tb/tb_mem_load_unit.sv
// ============================================================================
// Module  : tb_mem_load_unit
// Purpose : Directed scoreboard bench for mem_load_unit (RESP_TIMEOUT = 4).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_load_unit;
  import mem_pkg::*;

  localparam int RESP_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_LoadReq;
  logic [2:0]  MEM_LoadType;
  logic [31:0] MEM_Addr;
  logic        MEM_Flush;
  logic        DMem_ReqValid;
  logic [31:0] DMem_ReqAddr;
  logic        DMem_ReqReady;
  logic        DMem_RespValid;
  logic [31:0] DMem_RespData;
  logic [31:0] MEM_ReadData;
  logic        MEM_ReadValid;
  logic        MEM_Stall;
  logic        MEM_BusErr;
  logic        MEM_AddrErr;

  mem_load_unit #(.RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .MEM_LoadReq    (MEM_LoadReq),
    .MEM_LoadType   (MEM_LoadType),
    .MEM_Addr       (MEM_Addr),
    .MEM_Flush      (MEM_Flush),
    .DMem_ReqValid  (DMem_ReqValid),
    .DMem_ReqAddr   (DMem_ReqAddr),
    .DMem_ReqReady  (DMem_ReqReady),
    .DMem_RespValid (DMem_RespValid),
    .DMem_RespData  (DMem_RespData),
    .MEM_ReadData   (MEM_ReadData),
    .MEM_ReadValid  (MEM_ReadValid),
    .MEM_Stall      (MEM_Stall),
    .MEM_BusErr     (MEM_BusErr),
    .MEM_AddrErr    (MEM_AddrErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind is one-hot {AddrErr, BusErr, ReadValid}
  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (MEM_ReadValid || MEM_BusErr || MEM_AddrErr)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {29'b0, MEM_AddrErr, MEM_BusErr, MEM_ReadValid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("event_kind", {29'b0, MEM_AddrErr, MEM_BusErr, MEM_ReadValid}, {29'b0, e.kind});
        check("event_data", MEM_ReadData, e.data);
        check("event_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rdy: cycles ReqReady stays low; rsp: cycles from handshake to response
  task automatic do_load(input string nm, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp,
                         input int rdy, input int rsp, input bit flush_done);
    int c0;
    c0 = cyc;
    MEM_LoadReq  = 1'b1;
    MEM_LoadType = t;
    MEM_Addr     = a;
    if (!flush_done) sb.push_back('{3'b001, exp, 32'(c0 + 2 + rdy + rsp)});
    #1;
    check1({nm, "_stall_idle"}, MEM_Stall, 1'b1);
    step();
    MEM_LoadReq = 1'b0;
    for (int i = 0; i < rdy; i++) begin
      check1({nm, "_reqvalid"}, DMem_ReqValid, 1'b1);
      check({nm, "_reqaddr"}, DMem_ReqAddr, {a[31:2], 2'b00});
      check1({nm, "_stall_req"}, MEM_Stall, 1'b1);
      step();
    end
    DMem_ReqReady = 1'b1;
    check1({nm, "_reqvalid_hs"}, DMem_ReqValid, 1'b1);
    check({nm, "_reqaddr_hs"}, DMem_ReqAddr, {a[31:2], 2'b00});
    if (rsp == 0) begin
      DMem_RespValid = 1'b1;
      DMem_RespData  = d;
    end
    step();
    DMem_ReqReady = 1'b0;
    if (rsp > 0) begin
      for (int i = 1; i < rsp; i++) begin
        check1({nm, "_stall_wait"}, MEM_Stall, 1'b1);
        check1({nm, "_reqvalid_wait"}, DMem_ReqValid, 1'b0);
        step();
      end
      DMem_RespValid = 1'b1;
      DMem_RespData  = d;
      step();
    end
    DMem_RespValid = 1'b0;
    DMem_RespData  = 32'h0;
    if (flush_done) begin
      MEM_Flush = 1'b1;
      #1;
      check1({nm, "_flush_done_rv"}, MEM_ReadValid, 1'b0);
    end else begin
      check1({nm, "_stall_done"}, MEM_Stall, 1'b0);
    end
    step();
    MEM_Flush = 1'b0;
    if (!flush_done) check({nm, "_hold"}, MEM_ReadData, exp);
    check1({nm, "_rv_idle"}, MEM_ReadValid, 1'b0);
  endtask

  initial begin : stim
    int c0;
    rst            = 1'b1;
    MEM_LoadReq    = 1'b1;
    MEM_LoadType   = c_LW;
    MEM_Addr       = 32'h0;
    MEM_Flush      = 1'b0;
    DMem_ReqReady  = 1'b0;
    DMem_RespValid = 1'b0;
    DMem_RespData  = 32'h0;
    #2;
    check1("rst_reqvalid", DMem_ReqValid, 1'b0);
    check1("rst_stall", MEM_Stall, 1'b0);
    check1("rst_readvalid", MEM_ReadValid, 1'b0);
    check("rst_readdata", MEM_ReadData, 32'h0);
    check("rst_reqaddr", DMem_ReqAddr, 32'h0);
    check1("rst_buserr", MEM_BusErr, 1'b0);
    check1("rst_addrerr", MEM_AddrErr, 1'b0);
    MEM_LoadReq = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    do_load("lb_1003",  c_LB,  32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80, 0, 1, 1'b0);
    do_load("lhu_2002", c_LHU, 32'h0000_2002, 32'hBEEF_0001, 32'h0000_BEEF, 0, 1, 1'b0);
    do_load("lw_stall", c_LW,  32'h0000_4000, 32'hCAFE_F00D, 32'hCAFE_F00D, 4, 1, 1'b0);
    do_load("lbu_5001", c_LBU, 32'h0000_5001, 32'h1234_A5C3, 32'h0000_00A5, 0, 2, 1'b0);
    do_load("lh_same",  c_LH,  32'h0000_6000, 32'h0000_8001, 32'hFFFF_8001, 1, 0, 1'b0);
    do_load("lb_pos",   c_LB,  32'h0000_7000, 32'h0000_007F, 32'h0000_007F, 0, 1, 1'b0);
    do_load("lh_6002",  c_LH,  32'h0000_6002, 32'h7FFF_0000, 32'h0000_7FFF, 0, 1, 1'b0);
    do_load("undef_ty", 3'b111, 32'h0000_8000, 32'h1122_3344, 32'h1122_3344, 0, 1, 1'b0);
    do_load("lbu_9002", c_LBU, 32'h0000_9002, 32'h00EE_0000, 32'h0000_00EE, 0, 3, 1'b0);
    do_load("flush_dn", c_LW,  32'h0000_D000, 32'h5555_AAAA, 32'h5555_AAAA, 0, 1, 1'b1);
    do_load("lw_base",  c_LW,  32'h0000_E000, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 0, 1, 1'b0);

    // flush while the request is still waiting for ReqReady
    MEM_LoadReq = 1'b1; MEM_LoadType = c_LW; MEM_Addr = 32'h0000_A000;
    step();
    MEM_LoadReq = 1'b0;
    check1("fr_reqvalid", DMem_ReqValid, 1'b1);
    MEM_Flush = 1'b1;
    step();
    MEM_Flush = 1'b0;
    #1;
    check1("fr_reqvalid_after", DMem_ReqValid, 1'b0);
    check1("fr_stall_after", MEM_Stall, 1'b0);

    // flush in WAIT: the late response is drained silently
    MEM_LoadReq = 1'b1; MEM_Addr = 32'h0000_B000;
    step();
    MEM_LoadReq = 1'b0; DMem_ReqReady = 1'b1;
    step();
    DMem_ReqReady = 1'b0; MEM_Flush = 1'b1;
    step();
    MEM_Flush = 1'b0;
    check1("fw_stall_drain", MEM_Stall, 1'b1);
    check1("fw_reqvalid_drain", DMem_ReqValid, 1'b0);
    DMem_RespValid = 1'b1; DMem_RespData = 32'h1234_5678;
    step();
    DMem_RespValid = 1'b0; DMem_RespData = 32'h0;
    check1("fw_stall_idle", MEM_Stall, 1'b0);
    check("fw_readdata_hold", MEM_ReadData, 32'h0BAD_CAFE);
    step();

    // timeout: four WAIT cycles with no response
    c0 = cyc;
    MEM_LoadReq = 1'b1; MEM_LoadType = c_LW; MEM_Addr = 32'h0000_C000;
    sb.push_back('{3'b010, 32'h0, 32'(c0 + 6)});
    step();
    MEM_LoadReq = 1'b0; DMem_ReqReady = 1'b1;
    step();
    DMem_ReqReady = 1'b0;
    for (int i = 0; i < RESP_TIMEOUT; i++) begin
      check1("to_stall_wait", MEM_Stall, 1'b1);
      step();
    end
    check1("to_stall_done", MEM_Stall, 1'b0);
    step();
    DMem_RespValid = 1'b1; DMem_RespData = 32'hDEAD_BEEF;
    step();
    DMem_RespValid = 1'b0; DMem_RespData = 32'h0;
    check1("to_late_reqvalid", DMem_ReqValid, 1'b0);
    check("to_late_readdata", MEM_ReadData, 32'h0);

`ifdef LOAD_MISALIGN_TRAP_EN
    c0 = cyc;
    MEM_LoadReq = 1'b1; MEM_LoadType = c_LW; MEM_Addr = 32'h0000_3001;
    sb.push_back('{3'b100, 32'h0, 32'(c0 + 1)});
    #1;
    check1("mis_stall_idle", MEM_Stall, 1'b1);
    check1("mis_reqvalid0", DMem_ReqValid, 1'b0);
    step();
    MEM_LoadReq = 1'b0;
    check1("mis_reqvalid1", DMem_ReqValid, 1'b0);
    check1("mis_stall_done", MEM_Stall, 1'b0);
    step();
    check1("mis_reqvalid2", DMem_ReqValid, 1'b0);
`else
    do_load("lw_3001", c_LW, 32'h0000_3001, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 0, 1, 1'b0);
`endif

    // asynchronous reset in the middle of WAIT
    do_load("lw_pre_rst", c_LW, 32'h0000_F004, 32'h7777_1111, 32'h7777_1111, 0, 1, 1'b0);
    MEM_LoadReq = 1'b1; MEM_LoadType = c_LW; MEM_Addr = 32'h0000_F008;
    step();
    MEM_LoadReq = 1'b0; DMem_ReqReady = 1'b1;
    step();
    DMem_ReqReady = 1'b0;
    check1("rw_stall_wait", MEM_Stall, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check1("rw_stall", MEM_Stall, 1'b0);
    check1("rw_reqvalid", DMem_ReqValid, 1'b0);
    check("rw_reqaddr", DMem_ReqAddr, 32'h0);
    check("rw_readdata", MEM_ReadData, 32'h0);
    check1("rw_readvalid", MEM_ReadValid, 1'b0);
    step();
    rst = 1'b0;
    DMem_RespValid = 1'b1; DMem_RespData = 32'h9999_9999;
    step();
    DMem_RespValid = 1'b0; DMem_RespData = 32'h0;
    check1("rw_post_stall", MEM_Stall, 1'b0);
    check("rw_post_readdata", MEM_ReadData, 32'h0);

    step();
    step();
    step();
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/mem_load_unit.md
MEM_LOAD_UNIT -- requirements
Module: mem_load_unit

Interface
REQ-001 Parameter RESP_TIMEOUT, default 255, SHALL set the number of WAIT cycles without a response before a bus error is declared.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 MEM_LoadReq  input  1  MEM-stage instruction is a load.
REQ-005 MEM_LoadType  input  3  load kind: LB, LH, LW, LBU, LHU.
REQ-006 MEM_Addr  input  32  effective byte address from the ALU.
REQ-007 MEM_Flush  input  1  cancel the in-flight load.
REQ-008 DMem_ReqValid / DMem_ReqAddr  output  1 / 32  read request to data memory.
REQ-009 DMem_ReqReady  input  1  memory accepts the request.
REQ-010 DMem_RespValid / DMem_RespData  input  1 / 32  read response word.
REQ-011 MEM_ReadData  output  32  extended load result, consumed by the forwarding and writeback paths.
REQ-012 MEM_ReadValid  output  1  one-cycle pulse when MEM_ReadData is valid.
REQ-013 MEM_Stall  output  1  hold the pipeline.
REQ-014 MEM_BusErr / MEM_AddrErr  output  1 / 1  one-cycle error pulses.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, DRAIN and DONE.
REQ-016 IDLE: MEM_LoadReq=1 with MEM_Flush=0 -> latch address and type, go to REQ.
REQ-017 REQ: drive DMem_ReqValid=1 with DMem_ReqAddr={addr[31:2],2'b00}, both held stable until DMem_ReqReady=1.
REQ-018 REQ handshake -> WAIT; if DMem_RespValid is also 1 in that cycle, capture the response and go directly to DONE.
REQ-019 WAIT: DMem_RespValid=1 -> register the extended data into MEM_ReadData and go to DONE.
REQ-020 DONE lasts exactly 1 cycle: MEM_ReadValid=1, then IDLE.
REQ-021 Latency: with ReqReady=1 and the response 1 cycle later, request at cycle 0 gives ReadValid at cycle 3.
REQ-022 MEM_Stall = (state in REQ/WAIT/DRAIN) OR (state==IDLE AND MEM_LoadReq AND !MEM_Flush); it SHALL be low in DONE.
REQ-023 Timeout: an 8-bit-or-wider counter clears on entry to WAIT; when it reaches RESP_TIMEOUT, go to DONE with MEM_BusErr=1, MEM_ReadValid=0 and MEM_ReadData=0.
REQ-024 Flush in REQ before the handshake -> IDLE next cycle with DMem_ReqValid=0.
REQ-025 Flush on the handshake cycle or in WAIT -> DRAIN, which consumes exactly one response and then returns to IDLE, with no ReadValid.
REQ-026 Flush in DONE SHALL suppress that cycle's MEM_ReadValid.
REQ-027 Byte lanes are little-endian: byte n = data[8n+7:8n].
REQ-028 LB/LBU SHALL select the byte at addr[1:0], sign- or zero-extended.
REQ-029 LH/LHU SHALL select the halfword at addr[1], sign- or zero-extended.
REQ-030 LW, and any undefined type code, SHALL return the full word.
REQ-031 MEM_ReadData SHALL hold its last value outside DONE.

Reset
REQ-032 rst=1 SHALL force state=IDLE, timeout counter=0 and all outputs 0, independent of clk.
REQ-033 A response arriving after reset deassertion for a pre-reset request SHALL be ignored, because DMem_RespValid has no effect in IDLE.

Configuration
REQ-034 LOAD_MISALIGN_TRAP_EN defined: an LH/LHU with addr[0]=1, or an LW with addr[1:0]!=0, SHALL issue no request, go IDLE->DONE, and pulse MEM_AddrErr=1 with MEM_ReadData=0 and MEM_ReadValid=0.
REQ-035 LOAD_MISALIGN_TRAP_EN undefined: low address bits beyond lane selection SHALL be ignored, and MEM_AddrErr SHALL be tied 0.

Structure
REQ-036 Shared package mem_pkg SHALL hold the load-type encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101) and the FSM state enumeration.
REQ-037 Lane selection and extension SHALL be a combinational sub-module, load_extend (inputs: word, addr[1:0], type).

Verification
REQ-038 LB, addr 0x1003, RespData 0x80FF_1234 -> MEM_ReadData 0xFFFF_FF80, ReadValid at cycle 3.
REQ-039 LHU, addr 0x2002, RespData 0xBEEF_0001 -> 0x0000_BEEF; DMem_ReqAddr = 0x2000.
REQ-040 LW with ReqReady low for 4 cycles -> ReqValid and ReqAddr stable for 5 cycles, MEM_Stall high throughout.
REQ-041 Flush in WAIT, then response 0x1234_5678 -> no ReadValid; IDLE one cycle after the response.
REQ-042 RESP_TIMEOUT=4, no response -> MEM_BusErr pulse after 4 WAIT cycles, ReadData 0.
REQ-043 With macro defined: LW at 0x3001 -> no ReqValid, MEM_AddrErr pulse on the next cycle; rst asserted mid-WAIT -> immediate IDLE with outputs 0.
